// File: rtl/pixel_tap_sampler.sv
// pixel_tap_sampler: watches a raster pixel stream, captures three tap pixels per frame,
// thresholds them and debounces each tap over FILTER_DEPTH complete frames.
//
// Ports:
//   clock          sole clock, all state updates on its rising edge
//   reset          asynchronous, active-high reset
//   enable         run/stop; low forces IDLE and discards frame progress
//   data           8-bit pixel intensity, qualified by data_valid
//   data_valid     a pixel is present this cycle
//   line_start     this (or the next valid) pixel is column 0 of the next row
//   frame_start    new frame; also restarts the row count at 0
//   sample         filtered tap bits, bit k belongs to tap k
//   sample_valid   one-cycle pulse after a complete frame has been evaluated
//   missed_frames  saturating count of evaluated frames with a tap not captured

module pixel_tap_sampler #(
    parameter int         TAP0_X       = 63,
    parameter int         TAP0_Y       = 0,
    parameter int         TAP1_X       = 511,
    parameter int         TAP1_Y       = 0,
    parameter int         TAP2_X       = 1023,
    parameter int         TAP2_Y       = 0,
    parameter logic [7:0] THRESHOLD    = 8'd192,
    parameter int         FILTER_DEPTH = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic [7:0]  data,
    input  logic        data_valid,
    input  logic        line_start,
    input  logic        frame_start,
    output logic [2:0]  sample,
    output logic        sample_valid,
    output logic [15:0] missed_frames
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_FRAME = 2'd1,
        RUN        = 2'd2
    } state_t;

    localparam logic [10:0] CNT_MAX  = 11'd2047;
    localparam logic [15:0] MISS_MAX = 16'hFFFF;
    localparam logic [3:0]  DEPTH    = 4'(FILTER_DEPTH);

    // Tap coordinates packed so that index k selects tap k.
    localparam logic [2:0][10:0] TAP_X = {
        11'(TAP2_X), 11'(TAP1_X), 11'(TAP0_X)
    };
    localparam logic [2:0][10:0] TAP_Y = {
        11'(TAP2_Y), 11'(TAP1_Y), 11'(TAP0_Y)
    };

    function automatic logic [10:0] sat_inc11(input logic [10:0] v);
        return (v == CNT_MAX) ? v : v + 11'd1;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t           state_q, state_d;
    logic [10:0]      col_q, col_d;
    logic [10:0]      row_q, row_d;
    logic [2:0]       raw_q, raw_d;
    logic [2:0]       cap_q, cap_d;
    logic [2:0][3:0]  filt_q, filt_d;
    logic [2:0]       sample_q, sample_d;
    logic             valid_q, valid_d;
    logic [15:0]      missed_q, missed_d;

    // ------------------------------------------------------------------
    // Pixel position of the current cycle.
    // A start marker redefines the position before the pixel of the same
    // cycle is placed, so that pixel is column 0 of the new row.
    // ------------------------------------------------------------------
    logic [10:0] eff_row;
    logic [10:0] eff_col;
    logic [10:0] next_col;
    logic        pix_hi;
    logic [2:0]  hit;
    logic [2:0]  raw_upd;

    always_comb begin
        if (frame_start) begin
            eff_row = 11'd0;
        end else if (line_start) begin
            eff_row = sat_inc11(row_q);
        end else begin
            eff_row = row_q;
        end
        eff_col  = (frame_start || line_start) ? 11'd0 : col_q;
        next_col = data_valid ? sat_inc11(eff_col) : eff_col;
    end

    assign pix_hi = (data >= THRESHOLD);

    always_comb begin
        for (int k = 0; k < 3; k++) begin
            hit[k] = data_valid
                  && (eff_row == TAP_Y[k])
                  && (eff_col == TAP_X[k]);
        end
    end

    // A repeated hit within one frame simply overwrites the raw bit.
    assign raw_upd = (raw_q & ~hit) | ({3{pix_hi}} & hit);

    // ------------------------------------------------------------------
    // Frame evaluation of the debounce filter, used only when a complete
    // frame (all taps captured) ends in RUN.
    // ------------------------------------------------------------------
    logic [2:0]      eval_sample;
    logic [2:0][3:0] eval_filt;
    logic [3:0]      filt_inc;

    always_comb begin
        eval_sample = sample_q;
        eval_filt   = filt_q;
        filt_inc    = 4'd0;
        for (int k = 0; k < 3; k++) begin
            filt_inc = filt_q[k] + 4'd1;
            if (raw_q[k] == sample_q[k]) begin
                eval_filt[k] = 4'd0;
            end else if (filt_inc == DEPTH) begin
                eval_sample[k] = ~sample_q[k];
                eval_filt[k]   = 4'd0;
            end else begin
                eval_filt[k] = filt_inc;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        col_d    = col_q;
        row_d    = row_q;
        raw_d    = raw_q;
        cap_d    = cap_q;
        filt_d   = filt_q;
        sample_d = sample_q;
        valid_d  = 1'b0;
        missed_d = missed_q;

        if (!enable) begin
            // Stopped: drop all frame progress, keep the published sample.
            state_d = IDLE;
            col_d   = 11'd0;
            row_d   = 11'd0;
            cap_d   = 3'b000;
            filt_d  = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d = WAIT_FRAME;
                    col_d   = 11'd0;
                    row_d   = 11'd0;
                    cap_d   = 3'b000;
                    filt_d  = '0;
                end

                WAIT_FRAME: begin
                    // First frame boundary only arms; the frame before it
                    // was never fully observed, so nothing is evaluated.
                    if (frame_start) begin
                        state_d = RUN;
                        row_d   = eff_row;
                        col_d   = next_col;
                        cap_d   = hit;
                        raw_d   = raw_upd;
                    end
                end

                RUN: begin
                    row_d = eff_row;
                    col_d = next_col;
                    raw_d = raw_upd;
                    if (frame_start) begin
                        // Evaluate with the captures of the frame that just
                        // ended; a tap hit on this cycle belongs to the new one.
                        if (&cap_q) begin
                            sample_d = eval_sample;
                            filt_d   = eval_filt;
                            valid_d  = 1'b1;
                        end else if (missed_q != MISS_MAX) begin
                            missed_d = missed_q + 16'd1;
                        end
                        cap_d = hit;
                    end else begin
                        cap_d = cap_q | hit;
                    end
                end

                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            col_q    <= 11'd0;
            row_q    <= 11'd0;
            raw_q    <= 3'b000;
            cap_q    <= 3'b000;
            filt_q   <= '0;
            sample_q <= 3'b000;
            valid_q  <= 1'b0;
            missed_q <= 16'd0;
        end else begin
            state_q  <= state_d;
            col_q    <= col_d;
            row_q    <= row_d;
            raw_q    <= raw_d;
            cap_q    <= cap_d;
            filt_q   <= filt_d;
            sample_q <= sample_d;
            valid_q  <= valid_d;
            missed_q <= missed_d;
        end
    end

    assign sample        = sample_q;
    assign sample_valid  = valid_q;
    assign missed_frames = missed_q;

endmodule

// File: tb/tb_pixel_tap_sampler.sv
// tb_pixel_tap_sampler: directed and randomized frames for pixel_tap_sampler,
// checked every cycle against a frame-level behavioural model.

module tb_pixel_tap_sampler;

    localparam int T0X = 2;
    localparam int T0Y = 1;
    localparam int T1X = 0;
    localparam int T1Y = 0;
    localparam int T2X = 3;
    localparam int T2Y = 1;
    localparam int TH  = 192;
    localparam int FD  = 2;

    logic        clock       = 1'b0;
    logic        reset       = 1'b0;
    logic        enable      = 1'b0;
    logic [7:0]  data        = 8'd0;
    logic        data_valid  = 1'b0;
    logic        line_start  = 1'b0;
    logic        frame_start = 1'b0;
    logic [2:0]  sample;
    logic        sample_valid;
    logic [15:0] missed_frames;

    int total = 0;
    int bad   = 0;

    pixel_tap_sampler #(
        .TAP0_X(T0X), .TAP0_Y(T0Y),
        .TAP1_X(T1X), .TAP1_Y(T1Y),
        .TAP2_X(T2X), .TAP2_Y(T2Y),
        .THRESHOLD(8'(TH)),
        .FILTER_DEPTH(FD)
    ) dut (
        .clock(clock),
        .reset(reset),
        .enable(enable),
        .data(data),
        .data_valid(data_valid),
        .line_start(line_start),
        .frame_start(frame_start),
        .sample(sample),
        .sample_valid(sample_valid),
        .missed_frames(missed_frames)
    );

    always #5 clock = ~clock;

    // ---------------- reference model ----------------
    int       tx[3] = '{T0X, T1X, T2X};
    int       ty[3] = '{T0Y, T1Y, T2Y};
    bit       m_active;
    bit       m_armed;
    int       m_row;
    int       m_col;
    bit       m_cap[3];
    bit       m_raw[3];
    int       m_filt[3];
    bit [2:0] m_sample;
    bit       m_sv;
    int       m_missed;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_active = 0;
        m_armed  = 0;
        m_row    = 0;
        m_col    = 0;
        m_sample = 3'b000;
        m_sv     = 0;
        m_missed = 0;
        for (int k = 0; k < 3; k++) begin
            m_cap[k]  = 0;
            m_raw[k]  = 0;
            m_filt[k] = 0;
        end
    endtask

    task automatic model_eval();
        if (m_cap[0] && m_cap[1] && m_cap[2]) begin
            for (int k = 0; k < 3; k++) begin
                if (m_raw[k] == m_sample[k]) begin
                    m_filt[k] = 0;
                end else begin
                    m_filt[k] = m_filt[k] + 1;
                    if (m_filt[k] == FD) begin
                        m_sample[k] = ~m_sample[k];
                        m_filt[k]   = 0;
                    end
                end
            end
            m_sv = 1;
        end else if (m_missed < 65535) begin
            m_missed = m_missed + 1;
        end
    endtask

    task automatic model_step(bit fs, bit ls, bit dv, int d);
        m_sv = 0;
        if (!enable) begin
            m_active = 0;
            m_armed  = 0;
            m_row    = 0;
            m_col    = 0;
            for (int k = 0; k < 3; k++) begin
                m_cap[k]  = 0;
                m_filt[k] = 0;
            end
        end else if (!m_active) begin
            m_active = 1;
        end else begin
            if (fs) begin
                if (m_armed) model_eval();
                m_armed = 1;
                m_row   = 0;
                m_col   = 0;
                for (int k = 0; k < 3; k++) m_cap[k] = 0;
            end else if (ls && m_armed) begin
                m_row = (m_row >= 2047) ? 2047 : m_row + 1;
                m_col = 0;
            end
            if (m_armed && dv) begin
                for (int k = 0; k < 3; k++) begin
                    if (m_row == ty[k] && m_col == tx[k]) begin
                        m_raw[k] = (d >= TH);
                        m_cap[k] = 1;
                    end
                end
                m_col = (m_col >= 2047) ? 2047 : m_col + 1;
            end
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic step(bit fs, bit ls, bit dv, logic [7:0] d);
        frame_start = fs;
        line_start  = ls;
        data_valid  = dv;
        data        = d;
        model_step(fs, ls, dv, int'(d));
        @(posedge clock);
        @(negedge clock);
        chk("sample", 32'(sample), 32'(m_sample));
        chk("sample_valid", 32'(sample_valid), 32'(m_sv));
        chk("missed_frames", 32'(missed_frames), 32'(m_missed));
    endtask

    task automatic gap();
        if ($urandom_range(0, 3) == 0) step(0, 0, 0, 8'($urandom));
    endtask

    task automatic fs_step(bit coin, logic [7:0] v1);
        if (coin) step(1, 0, 1, v1);
        else step(1, 0, 0, 8'($urandom));
    endtask

    task automatic body(bit coin, logic [7:0] v0, logic [7:0] v1,
                        logic [7:0] v2, int nrows, int longn);
        if (!coin) begin
            gap();
            step(0, 0, 1, v1);
        end
        for (int c = 1; c < 5; c++) begin
            gap();
            step(0, 0, 1, 8'($urandom));
        end
        if (nrows > 1) begin
            if ($urandom_range(0, 1) == 1) begin
                step(0, 1, 1, 8'($urandom));
            end else begin
                step(0, 1, 0, 8'($urandom));
                gap();
                step(0, 0, 1, 8'($urandom));
            end
            gap();
            step(0, 0, 1, 8'($urandom));
            step(0, 0, 1, v0);
            gap();
            step(0, 0, 1, v2);
            for (int n = 0; n < longn; n++) step(0, 0, 1, 8'hFF);
        end
        gap();
    endtask

    task automatic do_reset();
        #2 reset = 1'b1;
        #1;
        chk("rst_sample", 32'(sample), 32'd0);
        chk("rst_valid", 32'(sample_valid), 32'd0);
        chk("rst_missed", 32'(missed_frames), 32'd0);
        model_reset();
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    // ---------------- test sequence ----------------
    initial begin
        model_reset();
        do_reset();

        enable = 1'b1;
        step(0, 0, 0, 8'd0);
        step(0, 0, 0, 8'd0);

        // Frame A twice: first boundary arms, second evaluates (filter 1).
        fs_step(1, 8'd10);
        chk("arm_no_valid", 32'(sample_valid), 32'd0);
        body(1, 8'd200, 8'd10, 8'd255, 2, 0);
        fs_step(1, 8'd10);
        chk("eval1_valid", 32'(sample_valid), 32'd1);
        chk("eval1_sample", 32'(sample), 32'd0);
        body(1, 8'd200, 8'd10, 8'd255, 2, 0);
        fs_step(1, 8'd10);
        chk("eval2_valid", 32'(sample_valid), 32'd1);
        chk("eval2_sample", 32'(sample), 32'b101);
        step(0, 0, 0, 8'd0);
        chk("valid_one_cycle", 32'(sample_valid), 32'd0);

        // Single dip on tap0 must not accumulate across a good frame.
        body(1, 8'd100, 8'd10, 8'd255, 2, 0);
        fs_step(1, 8'd10);
        body(1, 8'd200, 8'd10, 8'd255, 2, 0);
        fs_step(1, 8'd10);
        body(1, 8'd100, 8'd10, 8'd255, 2, 0);
        fs_step(1, 8'd10);
        chk("dip_sample", 32'(sample), 32'b101);

        // Frame missing row 1.
        body(1, 8'd200, 8'd10, 8'd255, 1, 0);
        fs_step(1, 8'd10);
        chk("miss_valid", 32'(sample_valid), 32'd0);
        chk("miss_count", 32'(missed_frames), 32'd1);
        chk("miss_sample", 32'(sample), 32'b101);

        // Enable dropped mid-frame.
        step(0, 0, 1, 8'd7);
        enable = 1'b0;
        step(1, 0, 1, 8'd255);
        step(0, 1, 1, 8'd255);
        chk("idle_sample", 32'(sample), 32'b101);
        enable = 1'b1;
        step(0, 0, 0, 8'd0);
        fs_step(1, 8'd10);
        chk("rearm_no_valid", 32'(sample_valid), 32'd0);
        body(1, 8'd200, 8'd10, 8'd255, 2, 0);

        // Tap1 pixel on the frame_start cycle belongs to the new frame.
        fs_step(1, 8'd255);
        body(1, 8'd200, 8'd255, 8'd255, 2, 0);
        fs_step(1, 8'd255);
        body(1, 8'd200, 8'd255, 8'd255, 2, 0);
        fs_step(1, 8'd10);
        chk("coin_sample", 32'(sample), 32'b111);

        // Long line: column saturates, no wrapped re-hit of tap0/tap2.
        body(1, 8'd50, 8'd10, 8'd50, 2, 3000);
        fs_step(1, 8'd10);
        body(1, 8'd50, 8'd10, 8'd50, 2, 3000);
        fs_step(1, 8'd10);
        chk("long_sample", 32'(sample), 32'b000);

        // Reset mid-frame: next boundary only arms.
        body(0, 8'd200, 8'd10, 8'd255, 1, 0);
        do_reset();
        step(0, 0, 0, 8'd0);
        fs_step(1, 8'd10);
        chk("post_rst_no_valid", 32'(sample_valid), 32'd0);
        body(1, 8'd200, 8'd10, 8'd255, 2, 0);

        // Randomized frames.
        for (int f = 0; f < 60; f++) begin
            logic [7:0] v0;
            logic [7:0] v1;
            logic [7:0] v2;
            bit         coin;
            int         nrows;
            v0    = 8'($urandom_range(150, 230));
            v1    = 8'($urandom_range(150, 230));
            v2    = 8'($urandom_range(150, 230));
            coin  = 1'($urandom_range(0, 1));
            nrows = ($urandom_range(0, 7) == 0) ? 1 : 2;
            fs_step(coin, v1);
            if ($urandom_range(0, 11) == 0) begin
                enable = 1'b0;
                step(0, 0, 1, 8'($urandom));
                enable = 1'b1;
            end
            body(coin, v0, v1, v2, nrows, 0);
        end
        fs_step(1, 8'd10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
